// File: rtl/bias_accum_relu_if.sv
// Valid/ready stream bundle used on both sides of bias_accum_relu.
// The master drives valid/data, the slave drives ready.
interface bias_accum_relu_if #(
  parameter int DATA_W = 8
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/bias_accum_relu.sv
// Per-lane bias + partial-sum accumulator with ReLU, requantizing shift and
// unsigned saturation, followed by a single-entry valid/ready output register.
module bias_accum_relu #(
  parameter int N_adder_tree = 16,
  parameter int DW           = 18,
  parameter int N_PARTIAL    = 4,
  parameter int ACC_W        = 22,
  parameter int SHIFT        = 4,
  parameter int OUT_W        = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_adder_tree*DW-1:0] bias,
  input  logic                       flush,
  bias_accum_relu_if.slave           in_port,
  bias_accum_relu_if.master          out_port
);

  localparam int                      CNT_W    = (N_PARTIAL > 1) ? $clog2(N_PARTIAL) : 1;
  localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(N_PARTIAL - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << OUT_W) - 1);

  // Floor shift, then clamp negatives to zero and large values to all-ones.
  function automatic logic [OUT_W-1:0] relu_sat(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W-1:0] r;
    r = sum >>> SHIFT;
    if (r[ACC_W-1]) begin
      relu_sat = {OUT_W{1'b0}};
    end else if (r > SAT_MAX) begin
      relu_sat = {OUT_W{1'b1}};
    end else begin
      relu_sat = r[OUT_W-1:0];
    end
  endfunction

  logic [CNT_W-1:0]              cnt_r;
  logic signed [ACC_W-1:0]       acc_r      [N_adder_tree];
  logic signed [ACC_W-1:0]       acc_next_s [N_adder_tree];
  logic                          out_valid_r;
  logic [N_adder_tree*OUT_W-1:0] out_data_r;
  logic [N_adder_tree*OUT_W-1:0] finish_data_s;
  logic                          ready_s;
  logic                          accept_s;
  logic                          last_s;
  logic                          first_s;

  assign last_s   = (cnt_r == LAST_CNT);
  assign first_s  = (cnt_r == {CNT_W{1'b0}});
  assign accept_s = in_port.valid & ready_s;

  assign in_port.ready  = ready_s;
  assign out_port.valid = out_valid_r;
  assign out_port.data  = out_data_r;

  // Only the last beat of a group needs room in the output register.
  always_comb begin
    ready_s = 1'b0;
    if (rst || flush) begin
      ready_s = 1'b0;
    end else if (last_s) begin
      ready_s = !out_valid_r || out_port.ready;
    end else begin
      ready_s = 1'b1;
    end
  end

  // Next accumulator value per lane and the finished activation it would produce.
  always_comb begin
    logic signed [DW-1:0]    bias_lane;
    logic signed [DW-1:0]    in_lane;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] in_ext;
    finish_data_s = {(N_adder_tree*OUT_W){1'b0}};
    for (int k = 0; k < N_adder_tree; k++) begin
      bias_lane = bias[DW*k +: DW];
      in_lane   = in_port.data[DW*k +: DW];
      bias_ext  = bias_lane;
      in_ext    = in_lane;
      if (first_s) begin
        acc_next_s[k] = bias_ext + in_ext;
      end else begin
        acc_next_s[k] = acc_r[k] + in_ext;
      end
      finish_data_s[OUT_W*k +: OUT_W] = relu_sat(acc_next_s[k]);
    end
  end

  // Beat counter, accumulators and the output holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {(N_adder_tree*OUT_W){1'b0}};
      for (int k = 0; k < N_adder_tree; k++) begin
        acc_r[k] <= {ACC_W{1'b0}};
      end
    end else begin
      if (flush) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (accept_s) begin
        if (last_s) begin
          cnt_r <= {CNT_W{1'b0}};
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
        for (int k = 0; k < N_adder_tree; k++) begin
          acc_r[k] <= acc_next_s[k];
        end
      end

      // A finish overrides a same-cycle pop, so back-to-back groups keep valid high.
      if (accept_s && last_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= finish_data_s;
      end else if (out_valid_r && out_port.ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bias_accum_relu.sv
// Directed, table-driven bench for bias_accum_relu with hand-computed results
// plus hand-written backpressure, flush and mid-group reset sequences.
module tb_bias_accum_relu;

  localparam int N  = 16;
  localparam int DW = 18;
  localparam int OW = 8;

  typedef struct {
    string          name;
    logic [DW-1:0]  bias_v;
    logic [3:0][DW-1:0] beat_v;
    logic [OW-1:0]  exp_v;
  } vec_t;

  logic            clk;
  logic            rst;
  logic            flush;
  logic [N*DW-1:0] bias;
  int              n_checks;
  int              n_errors;
  vec_t            vecs [13];

  bias_accum_relu_if #(.DATA_W(N*DW)) in_if ();
  bias_accum_relu_if #(.DATA_W(N*OW)) out_if ();

  bias_accum_relu dut (
    .clk      (clk),
    .rst      (rst),
    .bias     (bias),
    .flush    (flush),
    .in_port  (in_if),
    .out_port (out_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N*DW-1:0] rep_in(input logic [DW-1:0] v);
    logic [N*DW-1:0] r;
    for (int k = 0; k < N; k++) r[DW*k +: DW] = v;
    return r;
  endfunction

  function automatic logic [N*OW-1:0] rep_out(input logic [OW-1:0] v);
    logic [N*OW-1:0] r;
    for (int k = 0; k < N; k++) r[OW*k +: OW] = v;
    return r;
  endfunction

  function automatic vec_t mk(input string name, input int b, input int d0, input int d1,
                              input int d2, input int d3, input int e);
    vec_t v;
    v.name      = name;
    v.bias_v    = DW'(b);
    v.beat_v[0] = DW'(d0);
    v.beat_v[1] = DW'(d1);
    v.beat_v[2] = DW'(d2);
    v.beat_v[3] = DW'(d3);
    v.exp_v     = OW'(e);
    return v;
  endfunction

  task automatic check(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [N*DW-1:0] d);
    int t;
    in_if.valid = 1'b1;
    in_if.data  = d;
    #1;
    t = 0;
    while (!in_if.ready && t < 50) begin
      tick();
      t++;
    end
    if (!in_if.ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL beat_accept_timeout: in_ready stuck at 0 after %0d cycles", t);
    end
    tick();
    in_if.valid = 1'b0;
  endtask

  task automatic run_group(input logic [N*DW-1:0] b, input logic [3:0][N*DW-1:0] beats);
    bias = b;
    for (int i = 0; i < 4; i++) send_beat(beats[i]);
  endtask

  initial begin
    logic [3:0][N*DW-1:0] beats;
    logic [N*DW-1:0]      bvec;
    logic [N*OW-1:0]      evec;
    logic [N*OW-1:0]      a_data;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    flush = 1'b0;
    bias = '0;
    in_if.valid = 1'b0;
    in_if.data = '0;
    out_if.ready = 1'b1;

    vecs[0]  = mk("nominal",      160,     16,     16,     16,     16,  14);
    vecs[1]  = mk("relu_neg",     -2024,   100,    100,    100,    100, 0);
    vecs[2]  = mk("floor_m1",     0,       -1,     0,      0,      0,   0);
    vecs[3]  = mk("sat_500",      0,       2000,   2000,   2000,   2000, 255);
    vecs[4]  = mk("sat_4095",     4095,    0,      0,      0,      0,   255);
    vecs[5]  = mk("edge_4080",    4080,    0,      0,      0,      0,   255);
    vecs[6]  = mk("edge_4079",    4079,    0,      0,      0,      0,   254);
    vecs[7]  = mk("mixed_16",     0,       17,     -1,     0,      0,   1);
    vecs[8]  = mk("floor_15",     15,      0,      0,      0,      0,   0);
    vecs[9]  = mk("floor_m17",    -17,     0,      0,      0,      0,   0);
    vecs[10] = mk("max_pos",      131071,  131071, 131071, 131071, 131071, 255);
    vecs[11] = mk("max_neg",      -131072, -131072, -131072, -131072, -131072, 0);
    vecs[12] = mk("mixed_132",    100,     50,     -30,    20,     -8,  8);

    // Reset state
    tick();
    tick();
    check("rst_in_ready", 288'(in_if.ready), 288'(1'b0));
    check("rst_out_valid", 288'(out_if.valid), 288'(1'b0));
    check("rst_out_data", 288'(out_if.data), 288'(0));
    rst = 1'b0;
    #1;
    check("idle_in_ready", 288'(in_if.ready), 288'(1'b1));

    // Uniform-lane table
    foreach (vecs[v]) begin
      for (int i = 0; i < 4; i++) beats[i] = rep_in(vecs[v].beat_v[i]);
      run_group(rep_in(vecs[v].bias_v), beats);
      check({vecs[v].name, "_valid"}, 288'(out_if.valid), 288'(1'b1));
      check({vecs[v].name, "_data"}, 288'(out_if.data), 288'(rep_out(vecs[v].exp_v)));
      tick();
      check({vecs[v].name, "_pop"}, 288'(out_if.valid), 288'(1'b0));
    end

    // Per-lane ReLU/floor: lane0 -1624, lane1 -1, others nominal
    bvec = rep_in(DW'(160));
    bvec[DW*0 +: DW] = DW'(-2024);
    bvec[DW*1 +: DW] = DW'(0);
    for (int i = 0; i < 4; i++) begin
      beats[i] = rep_in(DW'(16));
      beats[i][DW*0 +: DW] = DW'(100);
      beats[i][DW*1 +: DW] = (i == 0) ? DW'(-1) : DW'(0);
    end
    evec = rep_out(OW'(14));
    evec[OW*0 +: OW] = OW'(0);
    evec[OW*1 +: OW] = OW'(0);
    run_group(bvec, beats);
    check("lanes_data", 288'(out_if.data), 288'(evec));
    tick();

    // Backpressure: A held, B stalls on its last beat
    out_if.ready = 1'b0;
    for (int i = 0; i < 4; i++) beats[i] = rep_in(DW'(16));
    run_group(rep_in(DW'(160)), beats);
    a_data = rep_out(OW'(14));
    check("bp_a_valid", 288'(out_if.valid), 288'(1'b1));
    bias = rep_in(DW'(0));
    for (int i = 0; i < 3; i++) send_beat(rep_in(DW'(2000)));
    in_if.valid = 1'b1;
    in_if.data = rep_in(DW'(2000));
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_stall_ready", 288'(in_if.ready), 288'(1'b0));
      check("bp_a_stable", 288'(out_if.data), 288'(a_data));
      check("bp_a_held", 288'(out_if.valid), 288'(1'b1));
      tick();
    end
    out_if.ready = 1'b1;
    #1;
    check("bp_release_ready", 288'(in_if.ready), 288'(1'b1));
    tick();
    in_if.valid = 1'b0;
    check("bp_b_valid", 288'(out_if.valid), 288'(1'b1));
    check("bp_b_data", 288'(out_if.data), 288'(rep_out(OW'(255))));
    tick();
    check("bp_b_pop", 288'(out_if.valid), 288'(1'b0));

    // Flush mid-group
    bias = rep_in(DW'(0));
    send_beat(rep_in(DW'(1000)));
    send_beat(rep_in(DW'(1000)));
    flush = 1'b1;
    in_if.valid = 1'b1;
    in_if.data = rep_in(DW'(1000));
    #1;
    check("flush_in_ready", 288'(in_if.ready), 288'(1'b0));
    tick();
    flush = 1'b0;
    in_if.valid = 1'b0;
    check("flush_out_valid", 288'(out_if.valid), 288'(1'b0));
    for (int i = 0; i < 4; i++) beats[i] = rep_in(DW'(16));
    run_group(rep_in(DW'(160)), beats);
    check("flush_next_data", 288'(out_if.data), 288'(rep_out(OW'(14))));
    check("flush_next_valid", 288'(out_if.valid), 288'(1'b1));
    tick();

    // Reset with a pending output and a partial group
    out_if.ready = 1'b0;
    run_group(rep_in(DW'(0)), '{default: rep_in(DW'(2000))});
    check("rstmid_pending", 288'(out_if.valid), 288'(1'b1));
    for (int i = 0; i < 3; i++) send_beat(rep_in(DW'(500)));
    rst = 1'b1;
    #1;
    check("rstmid_in_ready", 288'(in_if.ready), 288'(1'b0));
    tick();
    rst = 1'b0;
    check("rstmid_out_valid", 288'(out_if.valid), 288'(1'b0));
    check("rstmid_out_data", 288'(out_if.data), 288'(0));
    out_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) beats[i] = rep_in(DW'(16));
    run_group(rep_in(DW'(160)), beats);
    check("rstmid_fresh_valid", 288'(out_if.valid), 288'(1'b1));
    check("rstmid_fresh_data", 288'(out_if.data), 288'(rep_out(OW'(14))));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
